// File: rtl/ram_stream_reader.sv
// Walks LEN words of an async-read Ram from BASE and streams them out through a 2-entry skid FIFO.
// Optional bounds check against DEPTH is enabled by defining RAM_READER_BOUNDS_EN (adds the err port).
module ram_stream_reader #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    ram_addr,
    input  logic [DW-1:0]    ram_rdata,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    output logic             m_last,
    input  logic             m_ready
`ifdef RAM_READER_BOUNDS_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    if (DEPTH < 1) begin : g_depth_check
        $error("ram_stream_reader: DEPTH must be at least 1");
    end

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               done_q, done_d;
    logic [1:0]         count_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [DW-1:0]      data_q [2];
    logic [1:0]         last_q;
    logic               push;
    logic               pop;
    logic               last_in;

`ifdef RAM_READER_BOUNDS_EN
    logic               err_q, err_d;
    logic [AW:0]        end_addr;
    logic               reject;

    // End address is formed one bit wider so a base near the top of the space cannot wrap past the check.
    assign end_addr = {1'b0, base} + (AW+1)'(len);
    assign reject   = end_addr > (AW+1)'(DEPTH);
    assign err      = err_q;
`endif

    assign pop      = (count_q != 2'd0) && m_ready;
    // A full FIFO may still accept a word on the same edge the head leaves.
    assign push     = (state_q == S_RUN) && ((count_q != 2'd2) || pop);
    assign last_in  = (remain_q == CNT_W'(1));

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign ram_addr = addr_q;
    assign m_valid  = (count_q != 2'd0);
    assign m_data   = m_valid ? data_q[rd_ptr_q] : '0;
    assign m_last   = m_valid && last_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
`ifdef RAM_READER_BOUNDS_EN
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef RAM_READER_BOUNDS_EN
                    if (reject) begin
                        err_d = 1'b1;
                    end else
`endif
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        addr_d   = base;
                        remain_d = len;
                    end
                end
            end
            S_RUN: begin
                if (push) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (last_in) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            last_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
            end
`ifdef RAM_READER_BOUNDS_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
            count_q  <= count_q + {1'b0, push} - {1'b0, pop};
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            if (push) begin
                data_q[wr_ptr_q] <= ram_rdata;
                last_q[wr_ptr_q] <= last_in;
            end
`ifdef RAM_READER_BOUNDS_EN
            err_q    <= err_d;
`endif
        end
    end

endmodule
